// File: rtl/tmds_decode.sv
// TMDS receive channel decoder: finds symbol alignment via bitslip, recovers data/control/de.
// Latency: 1 cycle from din sample to de/c0/c1/dout; locked/bitslip registered on the same edge.
// No flow control: consumes one symbol per clkin, outputs are free-running and never stall.
//
// Ports:
//   clkin   - pixel clock (1x symbol rate)
//   rstin   - synchronous reset, active high
//   din     - 10-bit TMDS symbol, din[0] first bit on the wire
//   bitslip - one-cycle request to the deserializer to move its word boundary by one bit
//   locked  - symbol alignment achieved
//   de      - data enable (current symbol is pixel data)
//   c0, c1  - control bits, meaningful while de=0 (h_sync/v_sync on the blue channel)
//   dout    - decoded pixel byte, meaningful while de=1
module tmds_decode #(
    parameter int CTRL_RUN  = 8,
    parameter int TIMEOUT   = 4096,
    parameter int SLIP_WAIT = 4
) (
    input  logic       clkin,
    input  logic       rstin,
    input  logic [9:0] din,
    output logic       bitslip,
    output logic       locked,
    output logic       de,
    output logic       c0,
    output logic       c1,
    output logic [7:0] dout
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(CTRL_RUN + 1);
    localparam int SW = $clog2(SLIP_WAIT + 1);

    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RUN_DONE  = RW'(CTRL_RUN);
    localparam logic [SW-1:0] SLIP_LAST = SW'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   tmo_cnt, tmo_nxt;
    logic [RW-1:0]   run_cnt, run_nxt;
    logic [SW-1:0]   slip_cnt, slip_nxt;
    logic            bitslip_nxt;
    logic            locked_nxt;

    logic            is_tok;
    logic [1:0]      tok_c;
    logic [7:0]      q;
    logic [7:0]      dec;

    // Symbol classification and data decode, purely combinational on din.
    always_comb begin
        is_tok = 1'b1;
        tok_c  = 2'b00;
        case (din)
            10'h354: tok_c = 2'b00;
            10'h0AB: tok_c = 2'b01;
            10'h154: tok_c = 2'b10;
            10'h2AB: tok_c = 2'b11;
            default: is_tok = 1'b0;
        endcase

        // din[9] marks an inverted payload, din[8] selects XOR vs XNOR chaining.
        q      = din[9] ? ~din[7:0] : din[7:0];
        dec    = 8'h00;
        dec[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = din[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

    // Alignment FSM. Counter thresholds compare the registered count, so each
    // decision takes effect one edge after the count reaches its limit.
    always_comb begin
        state_nxt   = state;
        tmo_nxt     = tmo_cnt;
        run_nxt     = run_cnt;
        slip_nxt    = slip_cnt;
        bitslip_nxt = 1'b0;

        unique case (state)
            SEARCH: begin
                run_nxt = is_tok ? (run_cnt + RW'(1)) : '0;
                tmo_nxt = tmo_cnt + TW'(1);
                // Lock is checked first so a run completing on the timeout cycle never slips.
                if (run_cnt == RUN_DONE) begin
                    state_nxt = LOCKED;
                    tmo_nxt   = '0;
                    run_nxt   = '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt   = SLIP;
                    bitslip_nxt = 1'b1;
                    tmo_nxt     = '0;
                    run_nxt     = '0;
                    slip_nxt    = '0;
                end
            end

            SLIP: begin
                // din is unreliable while the deserializer settles; just count.
                tmo_nxt  = '0;
                run_nxt  = '0;
                slip_nxt = slip_cnt + SW'(1);
                if (slip_cnt == SLIP_LAST) begin
                    state_nxt = SEARCH;
                    slip_nxt  = '0;
                end
            end

            LOCKED: begin
                // Loss of lock goes straight to SEARCH; the first slip needs a full SEARCH timeout.
                if (is_tok) begin
                    tmo_nxt = '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = SEARCH;
                    tmo_nxt   = '0;
                    run_nxt   = '0;
                end else begin
                    tmo_nxt = tmo_cnt + TW'(1);
                end
            end

            default: begin
                state_nxt = SEARCH;
                tmo_nxt   = '0;
                run_nxt   = '0;
                slip_nxt  = '0;
            end
        endcase

        locked_nxt = (state_nxt == LOCKED);
    end

    always_ff @(posedge clkin) begin
        if (rstin) begin
            state    <= SEARCH;
            tmo_cnt  <= '0;
            run_cnt  <= '0;
            slip_cnt <= '0;
            bitslip  <= 1'b0;
            locked   <= 1'b0;
            de       <= 1'b0;
            c0       <= 1'b0;
            c1       <= 1'b0;
            dout     <= 8'h00;
        end else begin
            state    <= state_nxt;
            tmo_cnt  <= tmo_nxt;
            run_cnt  <= run_nxt;
            slip_cnt <= slip_nxt;
            bitslip  <= bitslip_nxt;
            locked   <= locked_nxt;
            // Mask with the lock value being registered now so outputs never
            // disagree with the locked flag presented alongside them.
            if (!locked_nxt) begin
                de   <= 1'b0;
                c0   <= 1'b0;
                c1   <= 1'b0;
                dout <= 8'h00;
            end else if (is_tok) begin
                de   <= 1'b0;
                c0   <= tok_c[0];
                c1   <= tok_c[1];
                dout <= 8'h00;
            end else begin
                // c0/c1 keep the last control value across the active period.
                de   <= 1'b1;
                dout <= dec;
            end
        end
    end

endmodule

// File: tb/tb_tmds_decode.sv
// Testbench for tmds_decode: directed symbols, expected outputs queued per cycle, checked by a monitor.
// Latency under test: outputs one edge after the symbol is sampled.
// No flow control on the DUT; the bench models the deserializer rotating on each bitslip.
module tb_tmds_decode;

    localparam int T = 64;
    localparam int S = 4;
    localparam int N_RUN = 8;

    localparam logic [12:0] M_ALL = 13'h1FFF;
    localparam logic [12:0] M_SL  = 13'h1800;

    logic       clk = 1'b0;
    logic       rstin = 1'b1;
    logic [9:0] din = 10'h000;
    logic       bitslip, locked, de, c0, c1;
    logic [7:0] dout;

    int cyc = 0;
    int chk_cnt = 0;
    int err_cnt = 0;
    int off = 0;

    typedef struct {
        int          cyc;
        logic [12:0] val;
        logic [12:0] mask;
        string       name;
    } exp_t;

    exp_t sb[$];

    tmds_decode #(
        .CTRL_RUN (N_RUN),
        .TIMEOUT  (T),
        .SLIP_WAIT(S)
    ) dut (
        .clkin  (clk),
        .rstin  (rstin),
        .din    (din),
        .bitslip(bitslip),
        .locked (locked),
        .de     (de),
        .c0     (c0),
        .c1     (c1),
        .dout   (dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Deserializer model: each bitslip pulse moves the word boundary by one bit.
    always @(posedge clk) begin
        #1;
        if (bitslip === 1'b1) off = (off + 1) % 10;
    end

    // Monitor: compare every queued expectation due on this edge.
    always @(posedge clk) begin
        logic [12:0] act;
        exp_t e;
        #1;
        act = {bitslip, locked, de, c1, c0, dout};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk_cnt++;
            if (e.cyc != cyc || ((act & e.mask) !== (e.val & e.mask))) begin
                err_cnt++;
                $display("FAIL %s cyc=%0d due=%0d got={slip,lock,de,c1,c0,dout}=%h want=%h mask=%h",
                         e.name, cyc, e.cyc, act, e.val, e.mask);
            end
        end
    end

    function automatic logic [9:0] rotr(input logic [9:0] v, input int n);
        logic [19:0] w;
        w = {v, v};
        return w[n +: 10];
    endfunction

    task automatic drv(input logic [9:0] d, input logic r);
        @(negedge clk);
        din   = d;
        rstin = r;
    endtask

    task automatic expect_out(input string nm, input logic sl, input logic lk, input logic dv,
                              input logic cc1, input logic cc0, input logic [7:0] dd,
                              input logic [12:0] m);
        exp_t e;
        e.cyc  = cyc + 1;
        e.val  = {sl, lk, dv, cc1, cc0, dd};
        e.mask = m;
        e.name = nm;
        sb.push_back(e);
    endtask

    initial begin
        int kl;

        // Reset state, then a run of blanking tokens.
        drv(10'h354, 1'b1);
        expect_out("reset", 0, 0, 0, 0, 0, 8'h00, M_ALL);
        for (int i = 0; i < N_RUN; i++) begin
            drv(10'h354, 1'b0);
            expect_out("search_no_lock", 0, 0, 0, 0, 0, 8'h00, M_ALL);
        end

        // Lock appears on the edge after the 8th token; control tokens decode.
        drv(10'h0AB, 1'b0);
        expect_out("lock_c01", 0, 1, 0, 0, 1, 8'h00, M_ALL);
        drv(10'h154, 1'b0);
        expect_out("tok_c10", 0, 1, 0, 1, 0, 8'h00, M_ALL);
        drv(10'h2AB, 1'b0);
        expect_out("tok_c11", 0, 1, 0, 1, 1, 8'h00, M_ALL);

        // Data symbols; c0/c1 hold the last control value.
        drv(10'h1FF, 1'b0);
        expect_out("data_1ff", 0, 1, 1, 1, 1, 8'h01, M_ALL);
        drv(10'h2FF, 1'b0);
        expect_out("data_2ff", 0, 1, 1, 1, 1, 8'hFE, M_ALL);
        drv(10'h100, 1'b0);
        expect_out("data_100", 0, 1, 1, 1, 1, 8'h00, M_ALL);

        // Data-only stream: lock drops after T symbols without a token.
        drv(10'h354, 1'b0);
        expect_out("refresh_tok", 0, 1, 0, 0, 0, 8'h00, M_ALL);
        for (int i = 1; i <= T; i++) begin
            drv(10'h1FF, 1'b0);
            if (i < T) expect_out("locked_data", 0, 1, 1, 0, 0, 8'h01, M_ALL);
            else       expect_out("lock_lost", 0, 0, 0, 0, 0, 8'h00, M_ALL);
        end

        // 7 tokens + 1 data in SEARCH must not lock.
        for (int i = 0; i < 7; i++) begin
            drv(10'h354, 1'b0);
            expect_out("run7_no_lock", 0, 0, 0, 0, 0, 8'h00, M_ALL);
        end
        drv(10'h1FF, 1'b0);
        expect_out("run_broken", 0, 0, 0, 0, 0, 8'h00, M_ALL);
        for (int i = 0; i < N_RUN; i++) begin
            drv(10'h354, 1'b0);
            expect_out("rerun_no_lock", 0, 0, 0, 0, 0, 8'h00, M_ALL);
        end
        drv(10'h354, 1'b0);
        expect_out("relock", 0, 1, 0, 0, 0, 8'h00, M_ALL);

        // Reset while locked: outputs clear, a full fresh run is needed again.
        drv(10'h0AB, 1'b1);
        expect_out("rst_locked", 0, 0, 0, 0, 0, 8'h00, M_ALL);
        for (int i = 0; i < N_RUN; i++) begin
            drv(10'h354, 1'b0);
            expect_out("post_rst_no_lock", 0, 0, 0, 0, 0, 8'h00, M_SL);
        end
        drv(10'h354, 1'b0);
        expect_out("post_rst_lock", 0, 1, 0, 0, 0, 8'h00, M_ALL);

        // Reset on the would-be slip edge drops the pulse.
        drv(10'h354, 1'b1);
        expect_out("rst_pre_slip", 0, 0, 0, 0, 0, 8'h00, M_ALL);
        off = 7;
        for (int k = 1; k < T; k++) begin
            drv(rotr(10'h354, off), 1'b0);
            expect_out("misaligned_no_slip", 0, 0, 0, 0, 0, 8'h00, M_SL);
        end
        drv(rotr(10'h354, off), 1'b1);
        expect_out("rst_drops_slip", 0, 0, 0, 0, 0, 8'h00, M_ALL);

        // Reset during SLIP: next pulse only after a full fresh timeout.
        for (int k = 1; k <= T + 1; k++) begin
            drv(rotr(10'h354, off), 1'b0);
            expect_out("slip_timing_a", (k == T), 0, 0, 0, 0, 8'h00, M_SL);
        end
        drv(rotr(10'h354, off), 1'b1);
        expect_out("rst_in_slip", 0, 0, 0, 0, 0, 8'h00, M_ALL);
        for (int k = 1; k <= T; k++) begin
            drv(rotr(10'h354, off), 1'b0);
            expect_out("slip_timing_b", (k == T), 0, 0, 0, 0, 8'h00, M_SL);
        end

        // Full acquisition from a 7-bit misalignment: 3 slips, then lock.
        drv(10'h354, 1'b1);
        expect_out("rst_acq", 0, 0, 0, 0, 0, 8'h00, M_ALL);
        off = 7;
        kl = 3 * T + 3 * S + N_RUN + 1;
        for (int k = 1; k <= kl + 2; k++) begin
            drv(rotr(10'h354, off), 1'b0);
            expect_out("acquire",
                       (k == T) || (k == 2 * T + S) || (k == 3 * T + 2 * S),
                       (k >= kl), 0, 0, 0, 8'h00, M_SL);
        end
        drv(10'h2AB, 1'b0);
        expect_out("acq_tok_c11", 0, 1, 0, 1, 1, 8'h00, M_ALL);

        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            err_cnt++;
            $display("FAIL sb_drain pending=%0d required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
